// File: rtl/mem_stage.sv
// Memory-access stage of the 10-bit pipeline: issues loads/stores over a req/ack
// port, stalls upstream while an access is outstanding, and registers writeback.
module mem_stage #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ldst_en,
  input  logic       wr_en,
  input  logic [9:0] alu_out,
  input  logic [2:0] wr_reg,
  input  logic [9:0] t1,
  output logic       mem_req,
  output logic       mem_we,
  output logic [9:0] mem_addr,
  output logic [9:0] mem_wdata,
  input  logic [9:0] mem_rdata,
  input  logic       mem_ack,
  output logic       stall,
  output logic       wb_en,
  output logic [9:0] wb_data,
  output logic [2:0] wb_reg,
  output logic       err
);

  // Handshake: mem_req rises with the address/data and holds them stable until
  // the cycle mem_ack is sampled high (single-cycle pulse), or until the timeout.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       mem_req_n, mem_we_n;
  logic [9:0] mem_addr_n, mem_wdata_n;
  logic       wb_en_n;
  logic [9:0] wb_data_n;
  logic [2:0] wb_reg_n;
  logic       err_n;
  logic       cap_wr_en, cap_wr_en_n;
  logic [2:0] cap_wr_reg, cap_wr_reg_n;

  // stall doubles as the externally visible FSM state.
  assign stall = (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wb_en      <= 1'b0;
      wb_data    <= '0;
      wb_reg     <= '0;
      err        <= 1'b0;
      cap_wr_en  <= 1'b0;
      cap_wr_reg <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      wb_en      <= wb_en_n;
      wb_data    <= wb_data_n;
      wb_reg     <= wb_reg_n;
      err        <= err_n;
      cap_wr_en  <= cap_wr_en_n;
      cap_wr_reg <= cap_wr_reg_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    wb_en_n      = 1'b0;
    wb_data_n    = wb_data;
    wb_reg_n     = wb_reg;
    err_n        = 1'b0;
    cap_wr_en_n  = cap_wr_en;
    cap_wr_reg_n = cap_wr_reg;
    case (state)
      IDLE: begin
        case (ldst_en)
          2'b00: begin
            wb_en_n   = wr_en;
            wb_data_n = alu_out;
            wb_reg_n  = wr_reg;
          end
          2'b01: begin
            mem_req_n    = 1'b1;
            mem_we_n     = 1'b0;
            mem_addr_n   = alu_out;
            cap_wr_en_n  = wr_en;
            cap_wr_reg_n = wr_reg;
            cnt_n        = '0;
            state_n      = BUSY;
          end
          2'b10: begin
            mem_req_n   = 1'b1;
            mem_we_n    = 1'b1;
            mem_addr_n  = alu_out;
            mem_wdata_n = t1;
            cnt_n       = '0;
            state_n     = BUSY;
          end
          default: err_n = 1'b1;
        endcase
      end
      BUSY: begin
        cnt_n = cnt + 8'd1;
        // An ack on the timeout edge still completes the access cleanly.
        if (mem_ack) begin
          mem_req_n = 1'b0;
          cnt_n     = '0;
          state_n   = IDLE;
          if (!mem_we) begin
            wb_en_n   = cap_wr_en;
            wb_data_n = mem_rdata;
            wb_reg_n  = cap_wr_reg;
          end
        end else if (cnt == TMO_LAST) begin
          mem_req_n = 1'b0;
          err_n     = 1'b1;
          cnt_n     = '0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, load/store latency, timeout,
// reserved opcode, back-to-back accesses and asynchronous reset mid-access.
module tb_mem_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ldst_en;
  logic       wr_en;
  logic [9:0] alu_out;
  logic [2:0] wr_reg;
  logic [9:0] t1;
  logic       mem_req;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [9:0] mem_wdata;
  logic [9:0] mem_rdata;
  logic       mem_ack;
  logic       stall;
  logic       wb_en;
  logic [9:0] wb_data;
  logic [2:0] wb_reg;
  logic       err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ldst_en(ldst_en), .wr_en(wr_en), .alu_out(alu_out),
    .wr_reg(wr_reg), .t1(t1), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall(stall), .wb_en(wb_en), .wb_data(wb_data),
    .wb_reg(wb_reg), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ldst_en = 2'b00; wr_en = 1'b0; alu_out = '0; wr_reg = '0;
    t1 = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick; tick;
    chk("rst_mem_req", 16'(mem_req), 16'h0);
    chk("rst_mem_we", 16'(mem_we), 16'h0);
    chk("rst_mem_addr", 16'(mem_addr), 16'h0);
    chk("rst_mem_wdata", 16'(mem_wdata), 16'h0);
    chk("rst_wb_en", 16'(wb_en), 16'h0);
    chk("rst_wb_data", 16'(wb_data), 16'h0);
    chk("rst_wb_reg", 16'(wb_reg), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_stall", 16'(stall), 16'h0);
    rst = 1'b0;

    // ALU pass-through
    ldst_en = 2'b00; wr_en = 1'b1; alu_out = 10'h2A5; wr_reg = 3'd5;
    tick;
    chk("alu_wb_en", 16'(wb_en), 16'h1);
    chk("alu_wb_data", 16'(wb_data), 16'h2A5);
    chk("alu_wb_reg", 16'(wb_reg), 16'h5);
    chk("alu_mem_req", 16'(mem_req), 16'h0);
    chk("alu_stall", 16'(stall), 16'h0);

    // Load, ack on 3rd BUSY edge; upstream inputs changed to junk while busy
    ldst_en = 2'b01; wr_en = 1'b1; alu_out = 10'h010; wr_reg = 3'd3; mem_rdata = 10'h3FF;
    tick;
    chk("ld_req", 16'(mem_req), 16'h1);
    chk("ld_we", 16'(mem_we), 16'h0);
    chk("ld_addr", 16'(mem_addr), 16'h010);
    chk("ld_stall0", 16'(stall), 16'h1);
    chk("ld_wb_en0", 16'(wb_en), 16'h0);
    ldst_en = 2'b10; alu_out = 10'h123; t1 = 10'h321; wr_reg = 3'd1;
    tick;
    chk("ld_stall1", 16'(stall), 16'h1);
    chk("ld_addr_hold", 16'(mem_addr), 16'h010);
    tick;
    chk("ld_stall2", 16'(stall), 16'h1);
    chk("ld_we_hold", 16'(mem_we), 16'h0);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; ldst_en = 2'b00; wr_en = 1'b0;
    chk("ld_done_stall", 16'(stall), 16'h0);
    chk("ld_done_req", 16'(mem_req), 16'h0);
    chk("ld_wb_en", 16'(wb_en), 16'h1);
    chk("ld_wb_data", 16'(wb_data), 16'h3FF);
    chk("ld_wb_reg", 16'(wb_reg), 16'h3);
    chk("ld_err", 16'(err), 16'h0);

    // Store with immediate ack
    ldst_en = 2'b10; wr_en = 1'b1; alu_out = 10'h155; t1 = 10'h0AA;
    tick;
    chk("st_we", 16'(mem_we), 16'h1);
    chk("st_addr", 16'(mem_addr), 16'h155);
    chk("st_wdata", 16'(mem_wdata), 16'h0AA);
    chk("st_stall", 16'(stall), 16'h1);
    ldst_en = 2'b00; wr_en = 1'b0; mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("st_done_stall", 16'(stall), 16'h0);
    chk("st_done_req", 16'(mem_req), 16'h0);
    chk("st_wb_en", 16'(wb_en), 16'h0);

    // Timeout: 4 BUSY edges without ack
    ldst_en = 2'b01; wr_en = 1'b1; alu_out = 10'h077; wr_reg = 3'd6; mem_rdata = 10'h111;
    tick;
    ldst_en = 2'b00; wr_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick;
      chk($sformatf("to_stall_%0d", i), 16'(stall), 16'h1);
      chk($sformatf("to_err_%0d", i), 16'(err), 16'h0);
    end
    tick;
    chk("to_stall", 16'(stall), 16'h0);
    chk("to_req", 16'(mem_req), 16'h0);
    chk("to_err", 16'(err), 16'h1);
    chk("to_wb_en", 16'(wb_en), 16'h0);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("to_err_clr", 16'(err), 16'h0);
    chk("idle_ack_req", 16'(mem_req), 16'h0);
    chk("idle_ack_stall", 16'(stall), 16'h0);
    chk("idle_ack_wb_en", 16'(wb_en), 16'h0);

    // Ack on the timeout edge: ack wins
    ldst_en = 2'b01; wr_en = 1'b1; alu_out = 10'h0AB; wr_reg = 3'd4; mem_rdata = 10'h246;
    tick;
    ldst_en = 2'b00; wr_en = 1'b0;
    tick; tick; tick;
    chk("race_stall3", 16'(stall), 16'h1);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("race_err", 16'(err), 16'h0);
    chk("race_wb_en", 16'(wb_en), 16'h1);
    chk("race_wb_data", 16'(wb_data), 16'h246);
    chk("race_wb_reg", 16'(wb_reg), 16'h4);

    // Reserved opcode
    ldst_en = 2'b11; wr_en = 1'b1; alu_out = 10'h3C3;
    tick;
    chk("rsv_err", 16'(err), 16'h1);
    chk("rsv_wb_en", 16'(wb_en), 16'h0);
    chk("rsv_stall", 16'(stall), 16'h0);

    // Back-to-back load then store, each acked on first BUSY edge
    ldst_en = 2'b01; wr_en = 1'b1; alu_out = 10'h0C3; wr_reg = 3'd2; mem_rdata = 10'h2B4;
    tick;
    chk("b2b_ld_req", 16'(mem_req), 16'h1);
    chk("b2b_ld_we", 16'(mem_we), 16'h0);
    chk("b2b_ld_addr", 16'(mem_addr), 16'h0C3);
    chk("b2b_rsv_err_clr", 16'(err), 16'h0);
    mem_ack = 1'b1; ldst_en = 2'b10; alu_out = 10'h1E1; t1 = 10'h35A; wr_reg = 3'd7;
    tick;
    mem_ack = 1'b0;
    chk("b2b_ld_wb_en", 16'(wb_en), 16'h1);
    chk("b2b_ld_wb_data", 16'(wb_data), 16'h2B4);
    chk("b2b_ld_wb_reg", 16'(wb_reg), 16'h2);
    chk("b2b_ld_stall", 16'(stall), 16'h0);
    tick;
    chk("b2b_st_req", 16'(mem_req), 16'h1);
    chk("b2b_st_we", 16'(mem_we), 16'h1);
    chk("b2b_st_addr", 16'(mem_addr), 16'h1E1);
    chk("b2b_st_wdata", 16'(mem_wdata), 16'h35A);
    chk("b2b_st_stall", 16'(stall), 16'h1);
    mem_ack = 1'b1; ldst_en = 2'b00; wr_en = 1'b0;
    tick;
    mem_ack = 1'b0;
    chk("b2b_st_done_req", 16'(mem_req), 16'h0);
    chk("b2b_st_wb_en", 16'(wb_en), 16'h0);

    // Asynchronous reset in the middle of a store
    ldst_en = 2'b10; alu_out = 10'h200; t1 = 10'h001;
    tick;
    chk("ra_stall", 16'(stall), 16'h1);
    ldst_en = 2'b00;
    #2 rst = 1'b1;
    #1;
    chk("ra_req", 16'(mem_req), 16'h0);
    chk("ra_stall0", 16'(stall), 16'h0);
    chk("ra_wb_en", 16'(wb_en), 16'h0);
    chk("ra_addr", 16'(mem_addr), 16'h0);
    chk("ra_we", 16'(mem_we), 16'h0);
    #1 rst = 1'b0;
    ldst_en = 2'b00; wr_en = 1'b1; alu_out = 10'h0F0; wr_reg = 3'd7;
    tick;
    chk("post_rst_wb_en", 16'(wb_en), 16'h1);
    chk("post_rst_wb_data", 16'(wb_data), 16'h0F0);
    chk("post_rst_wb_reg", 16'(wb_reg), 16'h7);
    chk("post_rst_stall", 16'(stall), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 10-bit pipeline. It consumes the execute-to-memory register outputs and performs loads and stores over a req/ack data-memory port. It stalls the upstream pipeline while an access is outstanding and drives registered memory-to-writeback signals. Non-memory instructions pass through with one cycle of latency.

## Interface
- ACK_TIMEOUT, 15: maximum number of cycles in BUSY without mem_ack before the access is aborted. Range 1..255.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ldst_en  in  2  operation code from execute: 00 none, 01 load, 10 store, 11 reserved
- wr_en  in  1  register-writeback request for this instruction
- alu_out  in  10  ALU result; also the effective address for load and store
- wr_reg  in  3  destination register index
- t1  in  10  store data
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, 0 = read; registered
- mem_addr  out  10  memory address; registered
- mem_wdata  out  10  write data; registered
- mem_rdata  in  10  read data; sampled when mem_ack=1
- mem_ack  in  1  memory completion; single-cycle pulse
- stall  out  1  hold all upstream pipeline registers; equals (state==BUSY)
- wb_en  out  1  writeback enable to the writeback stage; registered
- wb_data  out  10  writeback data; registered
- wb_reg  out  3  writeback register index; registered
- err  out  1  one-cycle pulse on a reserved opcode or on timeout; registered

## Operation
- The FSM has two states: IDLE and BUSY.
- Reset (asynchronous, takes effect at any time, including mid-access):
  - state goes to IDLE and the timeout counter clears.
  - Every output is 0: mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_data, wb_reg, err, stall.
- IDLE, ldst_en=00: wb_en<=wr_en, wb_data<=alu_out, wb_reg<=wr_reg. State stays IDLE.
- IDLE, ldst_en=01 (load):
  - mem_req<=1, mem_we<=0, mem_addr<=alu_out.
  - Capture wr_en and wr_reg internally. wb_en<=0. Go to BUSY.
- IDLE, ldst_en=10 (store):
  - mem_req<=1, mem_we<=1, mem_addr<=alu_out, mem_wdata<=t1.
  - wb_en<=0. Go to BUSY.
- IDLE, ldst_en=11: treated as a NOP. wb_en<=0, err<=1 for one cycle. State stays IDLE.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata hold stable.
  - wb_en<=0 each cycle (bubble). The timeout counter increments each cycle.
  - The ldst_en, wr_en, alu_out, wr_reg and t1 inputs are ignored.
- BUSY with mem_ack=1:
  - mem_req<=0, counter<=0, go to IDLE.
  - Load: wb_en<=captured wr_en, wb_data<=mem_rdata, wb_reg<=captured wr_reg.
  - Store: wb_en<=0.
- BUSY timeout: if the counter reaches ACK_TIMEOUT-1 with mem_ack=0:
  - mem_req<=0, wb_en<=0, err<=1 for one cycle, go to IDLE.
  - Loaded data is discarded.
- mem_ack in IDLE is ignored.
- A load with wr_en=0 still performs the read; the resulting wb_en is 0.
- err is 0 in every cycle not named above.
- Addresses are 10 bits with no arithmetic, so there is no wrap handling.

## Timing
- Non-memory instruction: inputs sampled at edge N; wb_* valid after edge N (1-cycle latency).
- Memory access:
  - Inputs sampled at edge N; mem_req=1 and stall=1 after edge N.
  - If mem_ack=1 is sampled at edge N+k (k≥1): wb_* valid, mem_req=0 and stall=0 after edge N+k.
  - Total latency is k+1 cycles; minimum is 2 (ack on the first BUSY cycle).
- Stall rule: the upstream register advances at edge N, because stall is 0 before the request. It then holds from edge N+1 through the ack edge. The next instruction is therefore sampled exactly once, at the first edge after returning to IDLE.
- Timeout fires at the ACK_TIMEOUT-th BUSY edge without an ack.
- An ack and the timeout on the same edge: the ack wins and err stays 0.
- Back-to-back memory operations: the second one is sampled in the first IDLE cycle and re-enters BUSY with no dead cycle.

## Test plan
- Reset mid-access: store in BUSY, rst=1 pulsed between edges → mem_req, stall and wb_en go to 0 immediately; after release the FSM is IDLE and the next ALU op passes normally.
- ALU pass-through: ldst_en=00, wr_en=1, alu_out=0x2A5, wr_reg=5 → one edge later wb_en=1, wb_data=0x2A5, wb_reg=5; mem_req and stall stay 0.
- Load with 3-cycle ack delay: ldst_en=01, alu_out=0x010, wr_reg=3, mem_rdata=0x3FF, ack at the 3rd BUSY edge → mem_addr=0x010, mem_we=0, stall=1 for 3 cycles; then wb_en=1, wb_data=0x3FF, wb_reg=3.
- Store with immediate ack: ldst_en=10, alu_out=0x155, t1=0x0AA → mem_we=1, mem_addr=0x155, mem_wdata=0x0AA; ack on the 1st BUSY edge → wb_en=0, stall=1 for exactly one cycle.
- Timeout: ACK_TIMEOUT=4, load, mem_ack held 0 → exactly 4 BUSY cycles, then mem_req=0, err=1 for one cycle, wb_en=0; a later ack in IDLE is ignored.
- Reserved opcode plus back-to-back: ldst_en=11 → err pulse, wb_en=0. Then a load immediately followed by a store, each acked on its first BUSY edge → both requests issue and the store's address and data are correct.
